// File: rtl/encoder_8_3_pkg.sv
// encoder_8_3_pkg
// Shared types and constants for the registered 8-to-3 priority encoder.
//   ENC_IN_W / ENC_OUT_W : request vector width and encoded index width
//   enc_in_t / enc_idx_t : request vector and index types
//   ENC_IDX_RST          : index value held while in reset
//   idx_bit_mask()       : the set of request positions whose index has a given bit set
package encoder_8_3_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

  localparam enc_idx_t ENC_IDX_RST = 3'b000;

  // Bit b of the encoded index is 1 exactly when the (single) winning request
  // sits at a position p with p[b] == 1. This mask lists those positions, so
  // each index bit becomes a plain OR over the masked one-hot winner vector.
  function automatic enc_in_t idx_bit_mask(input int b);
    enc_in_t m;
    m = '0;
    for (int p = 0; p < ENC_IN_W; p++) begin
      m[p] = p[b];
    end
    return m;
  endfunction

endpackage

// File: rtl/encoder_8_3_core.sv
// encoder_8_3_core
// Purely combinational priority core.
//   Parameter PRIO_HIGH : 1 -> highest-numbered set bit wins, 0 -> lowest wins.
//   d     : request vector
//   idx   : index of the winning request (0 when d is all-zero)
//   valid : at least one request set
//   multi : two or more requests set (only with ENCODER_8_3_ONEHOT_CHK_EN)
module encoder_8_3_core
  import encoder_8_3_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  enc_in_t  d,
  output enc_idx_t idx,
  output logic     valid
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  ,
  output logic     multi
`endif
);

  // above_any[i] : some request at a position strictly above i
  // below_any[i] : some request at a position strictly below i
  // win          : one-hot (or zero) vector marking the winning request
  enc_in_t above_any;
  enc_in_t below_any;
  enc_in_t win;

  genvar gi;
  generate
    for (gi = 0; gi < ENC_IN_W; gi++) begin : g_bit
      // Shifting the unwanted positions out of an 8-bit value keeps each
      // term independent, so there is no ripple chain across the vector.
      assign above_any[gi] = |(d >> (gi + 1));
      assign below_any[gi] = |(d << (ENC_IN_W - gi));

      if (PRIO_HIGH) begin : g_high
        assign win[gi] = d[gi] & ~above_any[gi];
      end else begin : g_low
        assign win[gi] = d[gi] & ~below_any[gi];
      end
    end

    for (gi = 0; gi < ENC_OUT_W; gi++) begin : g_idx
      localparam enc_in_t MASK = idx_bit_mask(gi);
      assign idx[gi] = |(win & MASK);
    end
  endgenerate

  assign valid = |d;

`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  // Two or more bits are set exactly when some set bit has another set bit
  // above it.
  assign multi = |(d & above_any);
`endif

endmodule

// File: rtl/encoder_8_3.sv
// encoder_8_3
// Registered 8-to-3 priority encoder with one cycle of latency.
//   Parameter PRIO_HIGH : 1 -> highest-numbered set bit wins, 0 -> lowest wins.
//   clk   : clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset; clears y, valid and err at once
//   d     : request vector, sampled every rising edge
//   y     : registered index of the winning request
//   valid : registered "at least one request set"
//   err   : registered "two or more requests set"; the port exists only when
//           the macro ENCODER_8_3_ONEHOT_CHK_EN is defined
module encoder_8_3
  import encoder_8_3_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENC_IN_W-1:0]  d,
  output logic [ENC_OUT_W-1:0] y,
  output logic                 valid
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  ,
  output logic                 err
`endif
);

  enc_idx_t y_next;
  logic     valid_next;
  enc_idx_t y_reg;
  logic     valid_reg;

`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  logic err_next;
  logic err_reg;
`endif

  encoder_8_3_core #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_core (
    .d     (d),
    .idx   (y_next),
    .valid (valid_next)
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
    ,
    .multi (err_next)
`endif
  );

  // No enable: every edge captures a fresh sample, so consecutive inputs
  // produce consecutive outputs. Reset drops whatever sample was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= ENC_IDX_RST;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= y_next;
      valid_reg <= valid_next;
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;

`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_encoder_8_3.sv
// tb_encoder_8_3
// Self-checking bench for encoder_8_3. Two instances run side by side, one
// with PRIO_HIGH=1 and one with PRIO_HIGH=0, fed the same request vector.
// Works with and without ENCODER_8_3_ONEHOT_CHK_EN.
module tb_encoder_8_3;

  logic       clk;
  logic       rst_n = 1'b1;
  logic [7:0] d = 8'h00;

  logic [2:0] y_hi;
  logic       valid_hi;
  logic [2:0] y_lo;
  logic       valid_lo;
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  logic       err_hi;
  logic       err_lo;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  encoder_8_3 #(.PRIO_HIGH(1'b1)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .y     (y_hi),
    .valid (valid_hi)
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
    ,
    .err   (err_hi)
`endif
  );

  encoder_8_3 #(.PRIO_HIGH(1'b0)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .y     (y_lo),
    .valid (valid_lo)
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
    ,
    .err   (err_lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs, packed as {y_hi, valid_hi, y_lo, valid_lo, err_hi, err_lo}.
  logic [9:0] obs;
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
  assign obs = {y_hi, valid_hi, y_lo, valid_lo, err_hi, err_lo};
`else
  assign obs = {y_hi, valid_hi, y_lo, valid_lo, 2'b00};
`endif

  // Reference model: scan the request vector for the highest and lowest set
  // positions and count the set bits.
  function automatic logic [9:0] exp_of(input logic [7:0] v);
    int   hi;
    int   lo;
    logic any;
    logic e;
    hi  = 0;
    lo  = 0;
    any = (v != 8'h00);
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    for (int i = 7; i >= 0; i--) if (v[i]) lo = i;
`ifdef ENCODER_8_3_ONEHOT_CHK_EN
    e = ($countones(v) >= 2);
`else
    e = 1'b0;
`endif
    return {hi[2:0], any, lo[2:0], any, e, e};
  endfunction

  task automatic test_reset();
    logic [9:0] req;
    d = 8'h80;
    #2 rst_n = 1'b0;
    #1;
    req = 10'b0;
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL reset_immediate d=%b actual=%b required=%b", d, obs, req);
    end else $display("reset_immediate d=%b out=%b", d, obs);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] actual=%b required=%b", k, obs, req);
      end else $display("reset_hold[%0d] out=%b", k, obs);
    end
    // Release between edges: the very next edge must sample d normally.
    rst_n = 1'b1;
    @(posedge clk); #1;
    req = exp_of(d);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL reset_release d=%b actual=%b required=%b", d, obs, req);
    end else $display("reset_release d=%b out=%b", d, obs);
  endtask

  task automatic test_onehot_sweep();
    logic [9:0] req;
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      @(posedge clk); #1;
      req = {i[2:0], 1'b1, i[2:0], 1'b1, 2'b00};
      n_cmp++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL onehot[%0d] d=%b actual=%b required=%b", i, d, obs, req);
      end else $display("onehot[%0d] d=%b out=%b", i, d, obs);
    end
  endtask

  task automatic test_zero();
    logic [9:0] req;
    d = 8'h00;
    @(posedge clk); #1;
    req = 10'b0;
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL zero d=%b actual=%b required=%b", d, obs, req);
    end else $display("zero d=%b out=%b", d, obs);
  endtask

  task automatic test_multihot();
    logic [9:0] req;
    logic [7:0] pat [4];
    pat[0] = 8'hC0; pat[1] = 8'hFF; pat[2] = 8'h81; pat[3] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      d = pat[i];
      @(posedge clk); #1;
      req = exp_of(d);
      n_cmp++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL multihot[%0d] d=%b actual=%b required=%b", i, d, obs, req);
      end else $display("multihot[%0d] d=%b out=%b", i, d, obs);
    end
  endtask

  task automatic test_midstream_reset();
    logic [9:0] req;
    d = 8'h20;
    @(posedge clk); #1;
    req = exp_of(d);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mid_pre d=%b actual=%b required=%b", d, obs, req);
    end else $display("mid_pre d=%b out=%b", d, obs);
    #2 rst_n = 1'b0;
    #1;
    req = 10'b0;
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mid_clear actual=%b required=%b", obs, req);
    end else $display("mid_clear out=%b", obs);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    req = exp_of(d);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mid_release d=%b actual=%b required=%b", d, obs, req);
    end else $display("mid_release d=%b out=%b", d, obs);
  endtask

  task automatic test_back_to_back();
    logic [9:0] req;
    for (int i = 0; i < 150; i++) begin
      // Mix sparse vectors (one or two bits) with fully random ones.
      case ($urandom_range(0, 3))
        0:       d = 8'h01 << $urandom_range(0, 7);
        1:       d = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
        2:       d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        default: d = 8'($urandom);
      endcase
      @(posedge clk); #1;
      req = exp_of(d);
      n_cmp++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL b2b[%0d] d=%b actual=%b required=%b", i, d, obs, req);
      end else $display("b2b[%0d] d=%b out=%b", i, d, obs);
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_multihot();
    test_midstream_reset();
    test_back_to_back();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_8_3.md
# encoder_8_3

Registered 8-to-3 priority encoder. Converts an 8-bit request vector `d` into the 3-bit binary index of one set bit, plus a valid flag. Sits between request or interrupt lines and downstream index-consuming logic. Outputs are registered on `clk`, and the block clears asynchronously on `rst_n`.

## Interface
Parameters:
- `PRIO_HIGH`, default 1: 1 means the highest-numbered set bit wins; 0 means the lowest-numbered set bit wins.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `d` input 8: request vector; bit i asserted requests index i.
- `y` output 3: encoded index of the winning bit (registered).
- `valid` output 1: 1 when the registered sample had at least one bit set.
- `err` output 1: only present with `ENCODER_8_3_ONEHOT_CHK_EN`. 1 when the registered sample had two or more bits set.

## Operation
- Combinational core computes the index of the winning bit per `PRIO_HIGH`.
- One-hot input maps to its bit position:
  - `00000001` -> 0
  - `00000010` -> 1
  - …
  - `10000000` -> 7
- Multi-hot input, `PRIO_HIGH`=1: `11000000` -> 7.
- Multi-hot input, `PRIO_HIGH`=0: `11000000` -> 6.
- All-zero input: `y`=0 and `valid`=0. `y`=0 with `valid`=1 means bit 0 won.
- `valid` = OR-reduction of `d`, registered alongside `y`.
- No enable and no handshake. `d` is sampled every cycle, and outputs follow every cycle.

## Timing
- Latency is 1 cycle: `d` sampled at rising edge N appears on `y`, `valid` and `err` after edge N.
- `d` must be stable in the setup/hold window of each edge. Glitches between edges are ignored.
- Reset values: `y`=3'b000, `valid`=0, `err`=0. These apply immediately on `rst_n` falling, independent of `clk`.
- Reset asserted mid-stream discards the in-flight sample.
- On reset release, the first edge with `rst_n`=1 samples `d` normally. There is no extra warm-up cycle.
- Back-to-back changes of `d` on consecutive cycles produce consecutive correct outputs. There are no bubbles.

## Configuration
- Macro: `ENCODER_8_3_ONEHOT_CHK_EN`.
- When defined:
  - Port `err` exists.
  - `err` is the registered flag "popcount(`d`) >= 2", with the same latency and reset as `y`.
  - `y` and `valid` are unaffected: priority still resolves the index.
- When undefined:
  - Port `err` and its logic are absent.
  - The rest of the behaviour is identical.

## Structure
- Shared package `encoder_8_3_pkg` holds:
  - Constants `ENC_IN_W`=8 and `ENC_OUT_W`=3.
  - Typedefs `enc_in_t` (logic [7:0]) and `enc_idx_t` (logic [2:0]).
  - Reset constant `ENC_IDX_RST`=3'b000.
- One sub-module is natural: `encoder_8_3_core`. It is purely combinational, takes `d` and `PRIO_HIGH`, and produces the index, `valid` and the multi-hot flag.
- The top level instantiates `encoder_8_3_core` and registers its outputs with async active-low reset.

## Test plan
- Reset: assert `rst_n`=0 with `d`=`10000000` -> `y`=0, `valid`=0, `err`=0 immediately and throughout reset. No clock edge is needed.
- One-hot sweep: drive `d` = 1<<i for i=0..7, one per cycle -> one cycle later `y`=i and `valid`=1 each time, and `err`=0.
- Zero input: `d`=`00000000` -> next cycle `y`=0, `valid`=0, `err`=0.
- Multi-hot priority: `d`=`11000000` -> `PRIO_HIGH`=1 gives `y`=7, `valid`=1; `PRIO_HIGH`=0 gives `y`=6. With the macro defined, `err`=1.
- Mid-stream reset: drive `d`=`00100000`, then pulse `rst_n` low between edges -> outputs clear at once. The first edge after release shows `y`=5, `valid`=1 if `d` is held.
- Macro off: rebuild without `ENCODER_8_3_ONEHOT_CHK_EN` and rerun the sweep and multi-hot cases -> identical `y` and `valid`; no `err` port.
